// File: rtl/approx_col_reducer.sv
// Multi-cycle column reducer sharing one approximate 5:2 counter cell.
// Returns approximate and exact column sums plus a mismatch flag.
module approx_col_reducer #(
  parameter int NSLICE = 3,
  parameter int ACC_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5*NSLICE-1:0]   in_col,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_approx,
  output logic [ACC_W-1:0]      out_exact,
  output logic                  out_err,
  output logic [7:0]            err_cnt,
  output logic                  busy
);

  localparam int COL_W = 5 * NSLICE;
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [COL_W-1:0]  shreg;
  logic [ACC_W-1:0]  acc_a;
  logic [ACC_W-1:0]  acc_e;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        err_q;

  logic [4:0]        x;
  logic              w1;
  logic              w2;
  logic              w3;
  logic              s;
  logic              c;
  logic [1:0]        slice_a;
  logic [2:0]        slice_e;
  logic              fire_in;
  logic              fire_out;
  logic              mism;

  assign x  = shreg[4:0];
  assign w1 = x[0] | x[1];
  assign w2 = x[2] | w1;
  assign w3 = x[3] | w1;
  assign s  = x[4] ^ w3 ^ w2;
  assign c  = (x[4] & w3) | (x[4] & w2) | (w3 & w2);

  assign slice_a = {c, s};
  assign slice_e = {2'b00, x[0]} + {2'b00, x[1]}
                 + {2'b00, x[2]} + {2'b00, x[3]}
                 + {2'b00, x[4]};

  assign fire_in  = (state == IDLE) && in_valid;
  assign fire_out = (state == DONE) && out_ready;
  assign mism     = (acc_a != acc_e);

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_approx = (state == DONE) ? acc_a : '0;
  assign out_exact  = (state == DONE) ? acc_e : '0;
  assign out_err    = (state == DONE) && mism;
  assign err_cnt    = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN:  if (idx == LAST) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Column capture, slice shifting and accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      acc_a <= '0;
      acc_e <= '0;
      idx   <= '0;
    end else if (fire_in) begin
      shreg <= in_col;
      acc_a <= '0;
      acc_e <= '0;
      idx   <= '0;
    end else if (state == RUN) begin
      shreg <= shreg >> 5;
      acc_a <= acc_a + ACC_W'(slice_a);
      acc_e <= acc_e + ACC_W'(slice_e);
      idx   <= idx + IDX_W'(1);
    end
  end

  // Saturating count of delivered mismatching columns
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (fire_out && mism && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_approx_col_reducer.sv
// Directed and randomized checks of approx_col_reducer against
// a slice-sum reference model.
module tb_approx_col_reducer;

  localparam int NS = 3;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [14:0]   in_col;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_approx;
  logic [AW-1:0] out_exact;
  logic          out_err;
  logic [7:0]    err_cnt;
  logic          busy;

  int total;
  int bad;
  int em;

  approx_col_reducer #(.NSLICE(NS), .ACC_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_col(in_col),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_approx(out_approx),
    .out_exact(out_exact),
    .out_err(out_err),
    .err_cnt(err_cnt),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Approximate slice value equals the number of ones among
  // x4, w3, w2 (s + 2c is their bit count).
  function automatic int approx_ref(input logic [14:0] col);
    int sum;
    int xv;
    int w1;
    sum = 0;
    for (int k = 0; k < NS; k++) begin
      xv = int'((col >> (5 * k)) & 15'h1F);
      w1 = ((xv & 1) | ((xv >> 1) & 1));
      sum += ((xv >> 4) & 1);
      sum += (((xv >> 3) & 1) | w1);
      sum += (((xv >> 2) & 1) | w1);
    end
    return sum;
  endfunction

  task automatic run_col(input logic [14:0] col, input bit early,
                         input int hold);
    int lat;
    int ea;
    int ee;
    ea = approx_ref(col);
    ee = $countones(col);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_col    = col;
    out_ready = early;
    @(negedge clk);
    in_valid = 1'b0;
    in_col   = 15'($urandom);
    chk("busy_run", busy, 1);
    chk("in_ready_run", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, NS);
    chk("approx", out_approx, ea);
    chk("exact", out_exact, ee);
    chk("err", out_err, (ea != ee));
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1;
        in_col   = 15'($urandom);
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_approx", out_approx, ea);
        chk("hold_exact", out_exact, ee);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_busy", busy, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    if (ea != ee && em < 255) em++;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_err_cnt", err_cnt, em);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    total     = 0;
    bad       = 0;
    em        = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_col    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_approx", out_approx, 0);
    chk("rst_exact", out_exact, 0);
    chk("rst_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_busy", busy, 0);

    run_col(15'h7FFF, 1'b1, 0);
    chk("all_ones_cnt", err_cnt, 1);
    run_col(15'b10000_01000_00100, 1'b1, 0);
    chk("exact_match_cnt", err_cnt, 1);
    run_col(15'h0001, 1'b0, 5);
    chk("approx_above_cnt", err_cnt, 2);

    @(negedge clk);
    in_valid = 1'b1;
    in_col   = 15'h7FFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    em  = 0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_err_cnt", err_cnt, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("abort_no_output", seen, 0);

    for (int i = 0; i < 40; i++) begin
      run_col(15'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 256; i++) begin
      run_col(15'h7FFF, 1'b1, 0);
    end
    chk("saturate", err_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_col_reducer.md
# approx_col_reducer

Multi-cycle column reducer that time-shares a single approximate 5:2 counter cell across a wide partial-product column. A column of 5·NSLICE bits is accepted over a valid/ready handshake and fed to the counter one 5-bit slice per cycle. The weighted counter outputs are accumulated alongside an exact popcount, and both results are returned with a mismatch flag. The block sits between partial-product generation and the final adder in the approximate-multiplier evaluation datapath. A saturating error counter supports accuracy characterisation.

## Interface
- NSLICE, 3, number of 5-bit slices per column (≥1)
- ACC_W, 5, accumulator width; must satisfy 2^ACC_W > 5·NSLICE
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  column offered
- in_ready  output  1  block can accept a column
- in_col  input  5·NSLICE  column bits; slice k = in_col[5k+4:5k]
- out_valid  output  1  results available
- out_ready  input  1  consumer takes results
- out_approx  output  ACC_W  sum of approximate slice values
- out_exact  output  ACC_W  exact popcount of column
- out_err  output  1  out_approx != out_exact
- err_cnt  output  8  saturating count of delivered columns with out_err=1
- busy  output  1  state != IDLE

## Operation
- Approximate cell function, per slice x[4:0]:
  - w1 = x0|x1, w2 = x2|w1, w3 = x3|w1
  - s = x4^w3^w2, c = majority(x4,w3,w2)
  - slice value = s + 2c, range 0..3
- Exact slice value = popcount(x), range 0..5.
- FSM states:
  - IDLE: in_ready=1. On in_valid: capture in_col into a shift register, clear both accumulators, clear slice index, go to RUN.
  - RUN: each cycle, process the low slice of the shift register. Add its approximate value to acc_a and its popcount to acc_e, shift right by 5, and increment the index. After slice NSLICE−1 is processed, go to DONE.
  - DONE: out_valid=1. out_approx=acc_a, out_exact=acc_e, out_err=(acc_a!=acc_e). On out_ready: go to IDLE, and increment err_cnt if out_err=1, saturating at 255.
- in_ready=0 in RUN and DONE. in_valid and in_col are ignored outside IDLE.
- out_* data outputs hold stable while out_valid=1 and out_ready=0.
- Slices are processed LSB first. Accumulators are ACC_W wide and cannot overflow under the parameter rule.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, out_approx=0, out_exact=0, out_err=0, err_cnt=0, busy=0, accumulators and shift register 0.
- Reset takes effect at the next rising edge and overrides every other event.
- Reset asserted in RUN or DONE abandons the column with no output, and clears err_cnt.
- Accept at edge E0. Slice k is accumulated at edge E(k+1). DONE is entered at edge E(NSLICE).
- out_valid is first high in the cycle after E(NSLICE), giving an accept-to-valid latency of NSLICE cycles.
- When out_ready is already high in the first DONE cycle, the handshake completes at that edge. in_ready is high in the following cycle.
- Minimum column period is NSLICE+2 cycles. There is no back-to-back overlap.
- err_cnt updates on the same edge as the output handshake.

## Test plan
- Reset held for 2 cycles, then released → all outputs at reset values and in_ready=1 in the first cycle after release.
- NSLICE=3, in_col=15'h7FFF with out_ready=1 → out_valid 3 cycles after accept, out_approx=9, out_exact=15, out_err=1, err_cnt=1 after the handshake.
- in_col=15'b10000_01000_00100 → out_approx=3, out_exact=3, out_err=0, err_cnt unchanged.
- in_col=15'h0001 → out_approx=2, out_exact=1, out_err=1. Also check approximation above exact is reported.
- out_ready held low for 5 cycles in DONE while in_valid=1 with a new column → outputs stable, in_ready=0, new column not captured, busy=1.
- rst pulsed in the second RUN cycle → IDLE next cycle, out_valid never rises, err_cnt=0. Separately, 256 mismatching columns → err_cnt saturates at 255.
